// File: rtl/decode_out_cap_pkg.sv
// Shared types for the decode-stage capture buffer: state encoding and record layout.
package decode_out_cap_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_E_W    = 6;
  localparam int unsigned DEF_W_W    = 2;
  localparam int unsigned REC_W      = 2*DEF_DATA_W + DEF_E_W + DEF_W_W + 1;
  localparam int unsigned TS_W       = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_e;

  // npc lands in the MSBs of the packed record
  typedef struct packed {
    logic [DEF_DATA_W-1:0] npc;
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_E_W-1:0]    e_ctl;
    logic [DEF_W_W-1:0]    w_ctl;
    logic                  mem_ctl;
  } decode_rec_t;

endpackage

// File: rtl/decode_cap_fifo.sv
// Registered first-word-fall-through FIFO; a push into a full FIFO succeeds when a pop
// happens on the same edge, otherwise it is reported on drop_o.
module decode_cap_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic [WIDTH-1:0] last_q;
  logic             full, empty, do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & full & ~do_pop;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // When empty the output keeps showing the most recently popped record
  assign rdata_o = empty ? last_q : mem_q[rd_q];
  assign valid_o = ~empty;
  assign count_o = cnt_q;

endmodule

// File: rtl/decode_out_capture.sv
// Capture buffer for LC-3 decode outputs: warm-up skip, qualified sampling into a FIFO.
// Define DECODE_CAP_TSTAMP_EN to store a 32-bit cycle timestamp per entry (out_tstamp).
module decode_out_capture
  import decode_out_cap_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned E_W    = DEF_E_W,
  parameter int unsigned W_W    = DEF_W_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WARMUP = 7,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          enable_decode,
  input  logic [DATA_W-1:0]             instr_dout,
  input  logic [DATA_W-1:0]             npc_in,
  input  logic [E_W-1:0]                E_control,
  input  logic [W_W-1:0]                W_control,
  input  logic                          Mem_control,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*DATA_W+E_W+W_W:0]     out_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_cnt,
`ifdef DECODE_CAP_TSTAMP_EN
  output logic [TS_W-1:0]               out_tstamp,
`endif
  output logic [1:0]                    state_o
);

  localparam int unsigned RW   = 2*DATA_W + E_W + W_W + 1;
  localparam int unsigned WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  cap_state_e       state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             ovf_q;
  logic [CNT_W-1:0] drop_q;
  logic             push, drop;
  logic [RW-1:0]    rec;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          wcnt_d  = '0;
          state_d = (WARMUP == 0) ? ST_CAPTURE : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (stop)                                 state_d = ST_IDLE;
        else if (wcnt_q == WC_W'(WARMUP - 1))     state_d = ST_CAPTURE;
        else                                      wcnt_d  = wcnt_q + 1'b1;
      end
      ST_CAPTURE: begin
        if (stop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign push = (state_q == ST_CAPTURE) && enable_decode && !stop;
  assign rec  = {npc_in, instr_dout, E_control, W_control, Mem_control};

`ifdef DECODE_CAP_TSTAMP_EN
  logic [TS_W-1:0]    ts_q;
  logic [TS_W+RW-1:0] fifo_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + 1'b1;
  end

  decode_cap_fifo #(.WIDTH(TS_W + RW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .wdata_i ({ts_q, rec}),
    .pop_i   (out_ready),
    .rdata_o (fifo_rdata),
    .valid_o (out_valid),
    .drop_o  (drop),
    .count_o (count)
  );

  assign out_data   = fifo_rdata[RW-1:0];
  assign out_tstamp = fifo_rdata[TS_W+RW-1:RW];
`else
  decode_cap_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .wdata_i (rec),
    .pop_i   (out_ready),
    .rdata_o (out_data),
    .valid_o (out_valid),
    .drop_o  (drop),
    .count_o (count)
  );
`endif

  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_decode_out_capture.sv
// Scoreboard bench for decode_out_capture: a cycle model predicts state, occupancy and records.
module tb_decode_out_capture;
  import decode_out_cap_pkg::*;

  localparam int DATA_W = 16;
  localparam int E_W    = 6;
  localparam int W_W    = 2;
  localparam int DEPTH  = 8;
  localparam int WARMUP = 7;
  localparam int CNT_W  = 8;
  localparam int RW     = 2*DATA_W + E_W + W_W + 1;

  logic              clock, reset_n, start, stop, enable_decode;
  logic [DATA_W-1:0] instr_dout, npc_in;
  logic [E_W-1:0]    E_control;
  logic [W_W-1:0]    W_control;
  logic              Mem_control;
  logic              out_valid, out_ready, overflow;
  logic [RW-1:0]     out_data;
  logic [3:0]        count;
  logic [CNT_W-1:0]  drop_cnt;
  logic [1:0]        state_o;

  decode_out_capture #(
    .DATA_W(DATA_W), .E_W(E_W), .W_W(W_W),
    .DEPTH(DEPTH), .WARMUP(WARMUP), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
    .enable_decode(enable_decode), .instr_dout(instr_dout), .npc_in(npc_in),
    .E_control(E_control), .W_control(W_control), .Mem_control(Mem_control),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .state_o(state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [RW-1:0] mq[$];
  int            m_state, m_wcnt, m_drop;
  bit            m_ovf;
  logic [RW-1:0] m_last;

  function automatic logic [RW-1:0] cur_rec();
    decode_rec_t r;
    r.npc = npc_in; r.instr = instr_dout; r.e_ctl = E_control;
    r.w_ctl = W_control; r.mem_ctl = Mem_control;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_wcnt = 0; m_drop = 0; m_ovf = 0; m_last = '0;
  endtask

  task automatic model_step();
    bit pop, push;
    pop  = (mq.size() > 0) && out_ready;
    push = (m_state == 2) && enable_decode && !stop;
    if (pop) m_last = mq.pop_front();
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(cur_rec());
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    case (m_state)
      0: if (start && !stop) begin m_wcnt = 0; m_state = (WARMUP == 0) ? 2 : 1; end
      1: if (stop) m_state = 0;
         else if (m_wcnt == WARMUP - 1) m_state = 2;
         else m_wcnt++;
      default: if (stop) m_state = 0;
    endcase
  endtask

  task automatic compare_all();
    check_val("state", state_o, m_state);
    check_val("count", count, mq.size());
    check_val("valid", out_valid, mq.size() > 0);
    check_val("overflow", overflow, m_ovf);
    check_val("drop_cnt", drop_cnt, m_drop);
    check_val("data", out_data, (mq.size() > 0) ? mq[0] : m_last);
  endtask

  task automatic cyc();
    if (out_valid && out_ready) hs_cnt++;
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic drain();
    out_ready = 1;
    for (int k = 0; k < 20 && mq.size() > 0; k++) cyc();
    check_val("drain_empty", out_valid, 0);
  endtask

  task automatic do_warmup();
    start = 1; cyc(); start = 0;
    repeat (WARMUP) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 0; start = 0; stop = 0; enable_decode = 0;
    instr_dout = '0; npc_in = '0; E_control = '0; W_control = '0; Mem_control = 0;
    out_ready = 0;
    model_reset();
    #12;
    compare_all();
    check_val("rst_state", state_o, 0);
    check_val("rst_data", out_data, 0);
    @(negedge clock); reset_n = 1;

    // Warm-up timing: first push on the 8th edge after the start edge
    npc_in = 16'h3001; instr_dout = 16'h1021; E_control = 6'h2A; W_control = 2'b10; Mem_control = 1;
    enable_decode = 1; start = 1;
    cyc(); start = 0;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      check_val("wu_nopush", count, 0);
    end
    cyc();
    check_val("wu_count", count, 1);
    check_val("wu_first", out_data, {16'h3001, 16'h1021, 6'h2A, 2'b10, 1'b1});
    enable_decode = 0; stop = 1; cyc(); stop = 0;
    drain();

    // Qualifier alternating 1/0, consumer always ready
    hs_cnt = 0;
    out_ready = 1;
    do_warmup();
    for (int i = 0; i < 10; i++) begin
      enable_decode = (i % 2 == 0);
      npc_in = 16'h4000 + 16'(i); instr_dout = 16'h5000 + 16'(i);
      cyc();
    end
    enable_decode = 0; stop = 1; cyc(); stop = 0;
    repeat (3) cyc();
    check_val("qual_records", hs_cnt, 5);

    // Overflow: 12 samples into 8 entries with no consumer
    out_ready = 0;
    do_warmup();
    enable_decode = 1;
    for (int i = 0; i < 12; i++) begin
      npc_in = 16'h6000 + 16'(i); instr_dout = 16'h7000 + 16'(i);
      cyc();
    end
    check_val("ovf_count", count, 8);
    check_val("ovf_flag", overflow, 1);
    check_val("ovf_drops", drop_cnt, 4);
    check_val("ovf_head", out_data[RW-1 -: DATA_W], 16'h6000);

    // Full with simultaneous pop: no drop, occupancy constant
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      npc_in = 16'h6100 + 16'(i);
      cyc();
      check_val("fullpop_count", count, 8);
    end
    check_val("fullpop_drops", drop_cnt, 4);
    check_val("fullpop_head", out_data[RW-1 -: DATA_W], 16'h6003);
    enable_decode = 0; stop = 1; cyc(); stop = 0;
    drain();

    // Control: stop in warm-up, start in capture, start+stop in idle
    start = 1; cyc(); start = 0;
    repeat (3) cyc();
    stop = 1; cyc(); stop = 0;
    check_val("ctl_stop_wu", state_o, 0);
    enable_decode = 1;
    repeat (3) cyc();
    check_val("ctl_idle_nopush", count, 0);
    enable_decode = 0;
    do_warmup();
    check_val("ctl_capture", state_o, 2);
    start = 1; cyc(); start = 0;
    check_val("ctl_start_ign", state_o, 2);
    stop = 1; cyc(); stop = 0;
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    check_val("ctl_start_stop", state_o, 0);

    // Asynchronous reset mid-capture with five entries held
    out_ready = 0;
    do_warmup();
    enable_decode = 1;
    for (int i = 0; i < 5; i++) begin
      npc_in = 16'h8000 + 16'(i);
      cyc();
    end
    check_val("pre_rst_count", count, 5);
    #2 reset_n = 0;
    #1;
    check_val("arst_count", count, 0);
    check_val("arst_valid", out_valid, 0);
    check_val("arst_ovf", overflow, 0);
    check_val("arst_drops", drop_cnt, 0);
    check_val("arst_state", state_o, 0);
    model_reset();
    enable_decode = 0;
    @(negedge clock); reset_n = 1;
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
